// File: rtl/bp_table_sequencer.sv
// bp_table_sequencer: single write-port owner for the branch predictor BTB/PHT.
// Arbitrates a full table-clear sweep against queued commit-stage updates.
// Optional feature macro: BP_SWEEP_ON_RESET_EN (reset enters the sweep so the
// tables are cleared before the first prediction; otherwise reset lands in IDLE).
module bp_table_sequencer #(
    parameter int INDEX_WIDTH   = 6,
    parameter int HISTORY_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_req_i,
    output logic                     flush_busy_o,
    output logic                     flush_done_o,
    output logic                     pred_gate_o,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic                     upd_btb_wr_i,
    input  logic [INDEX_WIDTH-1:0]   upd_btb_index_i,
    input  logic [HISTORY_WIDTH-1:0] upd_pht_index_i,
    input  logic                     upd_agree_i,
    output logic                     btb_wr_en_o,
    output logic [INDEX_WIDTH-1:0]   btb_wr_index_o,
    output logic                     btb_clear_o,
    output logic                     pht_wr_en_o,
    output logic [HISTORY_WIDTH-1:0] pht_wr_index_o,
    output logic                     pht_wr_agree_o,
    output logic                     pht_init_o
);

    // The sweep counter must cover the larger of the two tables.
    localparam int SW = (INDEX_WIDTH > HISTORY_WIDTH) ? INDEX_WIDTH : HISTORY_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

`ifdef BP_SWEEP_ON_RESET_EN
    localparam state_t RESET_STATE = SWEEP;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    typedef struct packed {
        logic                     btb_wr;
        logic [INDEX_WIDTH-1:0]   btb_index;
        logic [HISTORY_WIDTH-1:0] pht_index;
        logic                     agree;
    } upd_t;

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   cnt;
    logic [SW-1:0]   cnt_next;
    logic            done_q;
    logic            done_next;

    upd_t            fifo_mem [FIFO_DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    upd_t            head;
    upd_t            upd_in;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // Ready depends only on registered FIFO state, so a pop never frees a slot
    // for a push in the same cycle.
    assign upd_ready_o = !fifo_full && !flush_req_i;
    assign push        = upd_valid_i && upd_ready_o;
    assign pop         = (state == IDLE) && !fifo_empty && !flush_req_i;
    assign head        = fifo_mem[rd_ptr[PW-1:0]];

    assign upd_in.btb_wr    = upd_btb_wr_i;
    assign upd_in.btb_index = upd_btb_index_i;
    assign upd_in.pht_index = upd_pht_index_i;
    assign upd_in.agree     = upd_agree_i;

    assign flush_busy_o = (state == SWEEP);
    assign pred_gate_o  = (state == SWEEP);
    assign flush_done_o = done_q;

    // State, sweep counter and completion pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            done_q <= done_next;
        end
    end

    // Next-state logic: a flush always (re)starts the sweep from index 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req_i) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end
            end
            SWEEP: begin
                if (flush_req_i) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + SW'(1);
                end
            end
            default: begin
                state_next = RESET_STATE;
                cnt_next   = '0;
            end
        endcase
    end

    // FIFO pointers; a flush discards every queued (now stale) update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_req_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= upd_in;
        end
    end

    // Write-port mux: sweep has absolute priority, otherwise drain the FIFO head.
    always_comb begin
        btb_wr_en_o    = 1'b0;
        btb_wr_index_o = '0;
        btb_clear_o    = 1'b0;
        pht_wr_en_o    = 1'b0;
        pht_wr_index_o = '0;
        pht_wr_agree_o = 1'b0;
        pht_init_o     = 1'b0;
        if (!rst_i) begin
            if (state == SWEEP) begin
                pht_wr_en_o    = 1'b1;
                pht_wr_index_o = cnt[HISTORY_WIDTH-1:0];
                pht_init_o     = 1'b1;
                if ((cnt >> INDEX_WIDTH) == '0) begin
                    btb_wr_en_o    = 1'b1;
                    btb_wr_index_o = cnt[INDEX_WIDTH-1:0];
                    btb_clear_o    = 1'b1;
                end
            end else if (pop) begin
                pht_wr_en_o    = 1'b1;
                pht_wr_index_o = head.pht_index;
                pht_wr_agree_o = head.agree;
                if (head.btb_wr) begin
                    btb_wr_en_o    = 1'b1;
                    btb_wr_index_o = head.btb_index;
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_table_sequencer.sv
// tb_bp_table_sequencer: directed vectors for bp_table_sequencer with
// hand-computed expectations (INDEX_WIDTH=6, HISTORY_WIDTH=8, FIFO_DEPTH=4).
// Reset expectations follow BP_SWEEP_ON_RESET_EN when it is defined.
module tb_bp_table_sequencer;

    localparam int NSWEEP = 256;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_req_i;
    logic       flush_busy_o;
    logic       flush_done_o;
    logic       pred_gate_o;
    logic       upd_valid_i;
    logic       upd_ready_o;
    logic       upd_btb_wr_i;
    logic [5:0] upd_btb_index_i;
    logic [7:0] upd_pht_index_i;
    logic       upd_agree_i;
    logic       btb_wr_en_o;
    logic [5:0] btb_wr_index_o;
    logic       btb_clear_o;
    logic       pht_wr_en_o;
    logic [7:0] pht_wr_index_o;
    logic       pht_wr_agree_o;
    logic       pht_init_o;

    int vectors     = 0;
    int miscompares = 0;

    // Updates pushed during the sweep in the FIFO-overflow step.
    logic       u_bw [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] u_bi [5] = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
    logic [7:0] u_pi [5] = '{8'h80, 8'h91, 8'hA2, 8'hB3, 8'hC4};
    logic       u_ag [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    bp_table_sequencer #(
        .INDEX_WIDTH   (6),
        .HISTORY_WIDTH (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_req_i     (flush_req_i),
        .flush_busy_o    (flush_busy_o),
        .flush_done_o    (flush_done_o),
        .pred_gate_o     (pred_gate_o),
        .upd_valid_i     (upd_valid_i),
        .upd_ready_o     (upd_ready_o),
        .upd_btb_wr_i    (upd_btb_wr_i),
        .upd_btb_index_i (upd_btb_index_i),
        .upd_pht_index_i (upd_pht_index_i),
        .upd_agree_i     (upd_agree_i),
        .btb_wr_en_o     (btb_wr_en_o),
        .btb_wr_index_o  (btb_wr_index_o),
        .btb_clear_o     (btb_clear_o),
        .pht_wr_en_o     (pht_wr_en_o),
        .pht_wr_index_o  (pht_wr_index_o),
        .pht_wr_agree_o  (pht_wr_agree_o),
        .pht_init_o      (pht_init_o)
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mk_word(input int be, input int bi, input int bc,
                                            input int pe, input int pi, input int ag,
                                            input int ini);
        return {13'd0, be[0], bi[5:0], bc[0], pe[0], pi[7:0], ag[0], ini[0]};
    endfunction

    function automatic logic [31:0] port_word();
        return {13'd0, btb_wr_en_o, btb_wr_index_o, btb_clear_o, pht_wr_en_o,
                pht_wr_index_o, pht_wr_agree_o, pht_init_o};
    endfunction

    function automatic logic [31:0] status_word();
        return {29'd0, flush_busy_o, pred_gate_o, flush_done_o};
    endfunction

    function automatic logic [31:0] upd_word(input int i);
        return mk_word(int'(u_bw[i]), u_bw[i] ? int'(u_bi[i]) : 0, 0, 1,
                       int'(u_pi[i]), int'(u_ag[i]), 0);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic bw, input logic [5:0] bi,
                                 input logic [7:0] pi, input logic ag, input logic fl);
        upd_valid_i     = v;
        upd_btb_wr_i    = bw;
        upd_btb_index_i = bi;
        upd_pht_index_i = pi;
        upd_agree_i     = ag;
        flush_req_i     = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Walk a full sweep starting in the cycle that writes index 0; ends in the done cycle.
    task automatic sweepCheck(input string tag);
        for (int k = 0; k < NSWEEP; k++) begin
            checkOutput({tag, "_port"}, port_word(),
                        mk_word(k < 64 ? 1 : 0, k < 64 ? k : 0, k < 64 ? 1 : 0, 1, k, 0, 1));
            checkOutput({tag, "_status"}, status_word(), 32'b110);
            tick();
        end
        checkOutput({tag, "_done"}, status_word(), 32'b001);
    endtask

    initial begin
        rst_i = 1'b1;
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        #1;
        // Reset state.
`ifdef BP_SWEEP_ON_RESET_EN
        checkOutput("reset_status", status_word(), 32'b110);
`else
        checkOutput("reset_status", status_word(), 32'b000);
`endif
        checkOutput("reset_port", port_word(), 32'd0);
        checkOutput("reset_ready", {31'd0, upd_ready_o}, 32'd1);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
`ifdef BP_SWEEP_ON_RESET_EN
        sweepCheck("reset_sweep");
        tick();
        checkOutput("reset_done_once", status_word(), 32'b000);
`else
        checkOutput("idle_status", status_word(), 32'b000);
        checkOutput("idle_port", port_word(), 32'd0);
`endif

        // Single update, then a second one with no BTB allocation.
        applyStimulus(1, 1, 6'd5, 8'h3A, 1, 0);
        checkOutput("upd1_ready", {31'd0, upd_ready_o}, 32'd1);
        checkOutput("upd1_no_bypass", port_word(), 32'd0);
        tick();
        applyStimulus(1, 0, 6'd9, 8'hC4, 0, 0);
        checkOutput("upd1_write", port_word(), mk_word(1, 5, 0, 1, 8'h3A, 1, 0));
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        checkOutput("upd2_write", port_word(), mk_word(0, 0, 0, 1, 8'hC4, 0, 0));
        tick();
        checkOutput("upd_quiet", port_word(), 32'd0);

        // Queued updates discarded by a flush in IDLE.
        applyStimulus(1, 1, 6'd1, 8'h11, 1, 0);
        tick();
        applyStimulus(1, 1, 6'd2, 8'h22, 0, 0);
        checkOutput("q_a_write", port_word(), mk_word(1, 1, 0, 1, 8'h11, 1, 0));
        tick();
        applyStimulus(1, 0, 6'd3, 8'h33, 1, 0);
        checkOutput("q_b_write", port_word(), mk_word(1, 2, 0, 1, 8'h22, 0, 0));
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 1);
        checkOutput("flush_ready", {31'd0, upd_ready_o}, 32'd0);
        checkOutput("flush_no_write", port_word(), 32'd0);
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        sweepCheck("flush_sweep");
        checkOutput("flush_discard", port_word(), 32'd0);
        tick();
        checkOutput("flush_discard2", port_word(), 32'd0);

        // Five back-to-back updates during a sweep; the fifth is held off.
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 1);
        tick();
        for (int k = 0; k < NSWEEP; k++) begin
            if (k < 5) begin
                applyStimulus(1, u_bw[k], u_bi[k], u_pi[k], u_ag[k], 0);
            end
            checkOutput("ovf_ready", {31'd0, upd_ready_o}, (k < 4) ? 32'd1 : 32'd0);
            checkOutput("ovf_sweep_port", port_word(),
                        mk_word(k < 64 ? 1 : 0, k < 64 ? k : 0, k < 64 ? 1 : 0, 1, k, 0, 1));
            tick();
        end
        checkOutput("ovf_done", status_word(), 32'b001);
        checkOutput("ovf_write0", port_word(), upd_word(0));
        checkOutput("ovf_full_ready", {31'd0, upd_ready_o}, 32'd0);
        tick();
        checkOutput("ovf_write1", port_word(), upd_word(1));
        checkOutput("ovf_free_ready", {31'd0, upd_ready_o}, 32'd1);
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        checkOutput("ovf_write2", port_word(), upd_word(2));
        tick();
        checkOutput("ovf_write3", port_word(), upd_word(3));
        tick();
        checkOutput("ovf_write4", port_word(), upd_word(4));
        tick();
        checkOutput("ovf_drained", port_word(), 32'd0);

        // Flush re-asserted at cnt=100 restarts the sweep.
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 1);
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        for (int k = 0; k < 100; k++) begin
            tick();
        end
        checkOutput("restart_at100", port_word(), mk_word(0, 0, 0, 1, 100, 0, 1));
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 1);
        checkOutput("restart_status", status_word(), 32'b110);
        checkOutput("restart_ready", {31'd0, upd_ready_o}, 32'd0);
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        sweepCheck("restart_sweep");
        tick();
        checkOutput("restart_done_once", status_word(), 32'b000);

        // Reset mid-sweep with two entries queued.
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 1);
        tick();
        applyStimulus(1, u_bw[0], u_bi[0], u_pi[0], u_ag[0], 0);
        tick();
        applyStimulus(1, u_bw[1], u_bi[1], u_pi[1], u_ag[1], 0);
        tick();
        applyStimulus(0, 0, 6'd0, 8'd0, 0, 0);
        for (int k = 2; k < 50; k++) begin
            tick();
        end
        checkOutput("rst_at50", port_word(), mk_word(1, 50, 1, 1, 50, 0, 1));
        rst_i = 1'b1;
        #1;
        checkOutput("rst_strobes", port_word(), 32'd0);
        checkOutput("rst_done", {31'd0, flush_done_o}, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
`ifdef BP_SWEEP_ON_RESET_EN
        sweepCheck("rst_sweep");
        checkOutput("rst_fifo_empty", port_word(), 32'd0);
        tick();
        checkOutput("rst_fifo_empty2", port_word(), 32'd0);
`else
        checkOutput("rst_idle", status_word(), 32'b000);
        checkOutput("rst_fifo_empty", port_word(), 32'd0);
        checkOutput("rst_ready", {31'd0, upd_ready_o}, 32'd1);
        tick();
        checkOutput("rst_fifo_empty2", port_word(), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
